// File: rtl/conv_sched_ctrl.sv
// conv_sched_ctrl
//   Control-center scheduler for the single-CONV-layer NoC. Once per
//   timestep it sends one CFG packet to every PE, then a START packet to the
//   ifmap/filter memory. It then waits for the partial-sum adder to report,
//   over a 4-phase level handshake, that all outputs of that timestep are
//   summed. After TOT_TIME timesteps it pulses layer_done and returns to idle.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start         : one-cycle layer start request, sampled only when idle
//   pkt_data      : packet {src, dst, type, payload} towards the router
//   pkt_valid     : packet valid (registered)
//   pkt_ready     : router accepts the packet
//   add_done_req  : adder reports the current timestep complete (level)
//   add_done_ack  : acknowledge to the adder (level)
//   busy          : high in every state except IDLE
//   layer_done    : one-cycle pulse in the final state of a layer
//   timestep      : index of the current timestep
//   proto_err     : sticky; adder request seen while packets were being sent
//
// Handshake: a packet transfers on a rising edge where pkt_valid && pkt_ready.
// pkt_valid and pkt_data come straight from flops. While pkt_valid && !pkt_ready
// the FSM does not advance, so both are reloaded with unchanged values and
// stay stable. pkt_valid only falls after a transfer, or on reset.

module conv_sched_ctrl #(
    parameter int WIDTH      = 5,
    parameter int DATA_WIDTH = 20,
    parameter int NUM_PE     = 5,
    parameter int PE_BASE    = 0,
    parameter int MEM_ADDR   = 10,
    parameter int CC_ADDR    = 15,
    parameter int TOT_TIME   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] pkt_data,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    input  logic                  add_done_req,
    output logic                  add_done_ack,
    output logic                  busy,
    output logic                  layer_done,
    output logic [7:0]            timestep,
    output logic                  proto_err
);

    localparam int PW = DATA_WIDTH - 2*WIDTH - 2;

    localparam logic [WIDTH-1:0] SRC_ID   = WIDTH'(CC_ADDR);
    localparam logic [WIDTH-1:0] MEM_ID   = WIDTH'(MEM_ADDR);
    localparam logic [WIDTH-1:0] PE0_ID   = WIDTH'(PE_BASE);
    localparam logic [WIDTH-1:0] LAST_PE  = WIDTH'(NUM_PE - 1);
    localparam logic [7:0]       LAST_TS  = 8'(TOT_TIME - 1);
    localparam logic [1:0]       TYPE_CFG   = 2'b00;
    localparam logic [1:0]       TYPE_START = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_PE,
        S_KICK_MEM,
        S_WAIT_ADD,
        S_ACK,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pe_cnt, pe_cnt_nxt;
    logic [7:0]       ts, ts_nxt;
    logic             xfer;
    logic             send_nxt;
    logic [WIDTH-1:0] dst_nxt;
    logic [1:0]       type_nxt;
    logic [PW-1:0]    payload_nxt;

    assign xfer = pkt_valid && pkt_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pe_cnt <= '0;
            ts     <= '0;
        end else begin
            state  <= state_nxt;
            pe_cnt <= pe_cnt_nxt;
            ts     <= ts_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt  = state;
        pe_cnt_nxt = pe_cnt;
        ts_nxt     = ts;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_CFG_PE;
                    pe_cnt_nxt = '0;
                    ts_nxt     = '0;
                end
            end
            S_CFG_PE: begin
                if (xfer) begin
                    if (pe_cnt == LAST_PE) state_nxt = S_KICK_MEM;
                    else                   pe_cnt_nxt = pe_cnt + WIDTH'(1);
                end
            end
            S_KICK_MEM: begin
                if (xfer) state_nxt = S_WAIT_ADD;
            end
            S_WAIT_ADD: begin
                if (add_done_req) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (!add_done_req) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (ts == LAST_TS) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt  = S_CFG_PE;
                    ts_nxt     = ts + 8'd1;
                    pe_cnt_nxt = '0;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Packet fields are built from the next-state values so the registered
    // packet is already correct in the first cycle of a sending state.
    always_comb begin
        send_nxt    = (state_nxt == S_CFG_PE) || (state_nxt == S_KICK_MEM);
        dst_nxt     = (state_nxt == S_KICK_MEM) ? MEM_ID : PE0_ID + pe_cnt_nxt;
        type_nxt    = (state_nxt == S_KICK_MEM) ? TYPE_START : TYPE_CFG;
        payload_nxt = PW'(ts_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
        end else begin
            pkt_valid <= send_nxt;
            pkt_data  <= send_nxt ? {SRC_ID, dst_nxt, type_nxt, payload_nxt} : '0;
        end
    end

    // An adder request while packets are still going out is premature; it is
    // flagged but not consumed, since the adder keeps holding it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (add_done_req && (state == S_CFG_PE || state == S_KICK_MEM)) begin
            proto_err <= 1'b1;
        end
    end

    // ---------------- output decode ----------------
    always_comb begin
        busy         = (state != S_IDLE);
        layer_done   = (state == S_DONE);
        add_done_ack = (state == S_ACK);
        timestep     = ts;
    end

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Bench for conv_sched_ctrl: a full-size instance (5 PEs, 3 timesteps) and a
// minimal one (1 PE, 1 timestep). Expected packets are queued when a run is
// launched; a negedge monitor pops and compares on every transfer.
module tb_conv_sched_ctrl;

  localparam int DW = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // full-size instance
  logic          start, pkt_valid, pkt_ready, add_done_req, add_done_ack;
  logic          busy, layer_done, proto_err;
  logic [DW-1:0] pkt_data;
  logic [7:0]    timestep;

  // 1 PE / 1 timestep instance
  logic          s_start, s_pkt_valid, s_pkt_ready, s_req, s_ack;
  logic          s_busy, s_ld, s_perr;
  logic [DW-1:0] s_pkt_data;
  logic [7:0]    s_ts;

  conv_sched_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .add_done_req(add_done_req), .add_done_ack(add_done_ack),
    .busy(busy), .layer_done(layer_done), .timestep(timestep), .proto_err(proto_err)
  );

  conv_sched_ctrl #(.NUM_PE(1), .TOT_TIME(1)) u_small (
    .clk(clk), .rst(rst), .start(s_start),
    .pkt_data(s_pkt_data), .pkt_valid(s_pkt_valid), .pkt_ready(s_pkt_ready),
    .add_done_req(s_req), .add_done_ack(s_ack),
    .busy(s_busy), .layer_done(s_ld), .timestep(s_ts), .proto_err(s_perr)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_s_q[$];

  // monitor-owned bookkeeping
  int            start_cnt = 0, done_cnt = 0;
  int            s_start_cnt = 0, s_done_cnt = 0, s_busy_cnt = 0, s_ack_rise = 0;
  logic          prev_stall = 0, prev_ack = 0, prev_ld = 0, start_xfer = 0, s_prev_ack = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_pkt(input logic [4:0] dst, input logic [1:0] typ,
                                           input logic [7:0] ts);
    return {5'd15, dst, typ, ts};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0; prev_ack = 0; prev_ld = 0; start_xfer = 0; s_prev_ack = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", pkt_valid, 1);
        check("hold_data", pkt_data, prev_data);
      end
      prev_stall = pkt_valid && !pkt_ready;
      prev_data  = pkt_data;
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pkt_extra: got 0x%0h expected no packet", pkt_data);
        end else begin
          check("pkt", pkt_data, exp_q.pop_front());
        end
        if (pkt_data[9:8] == 2'b01) begin
          start_cnt++;
          start_xfer = 1;
        end else if (pkt_data[14:10] == 5'd0) begin
          start_xfer = 0;
        end
      end
      if (add_done_ack && !prev_ack) check("ack_after_start", start_xfer, 1);
      prev_ack = add_done_ack;
      if (prev_ld) check("busy_after_done", busy, 0);
      if (layer_done) begin
        done_cnt++;
        check("busy_in_done", busy, 1);
      end
      prev_ld = layer_done;

      if (s_pkt_valid && s_pkt_ready) begin
        if (exp_s_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL s_pkt_extra: got 0x%0h expected no packet", s_pkt_data);
        end else begin
          check("s_pkt", s_pkt_data, exp_s_q.pop_front());
        end
        if (s_pkt_data[9:8] == 2'b01) s_start_cnt++;
      end
      if (s_busy) s_busy_cnt++;
      if (s_ld) s_done_cnt++;
      if (s_ack && !s_prev_ack) s_ack_rise++;
      s_prev_ack = s_ack;
    end
  end

  // ---------------- drivers ----------------
  // One layer on the full-size instance; the loop also plays the adder:
  // req rises 4 cycles after each START transfer and falls 1 cycle after ack.
  task automatic run_layer(input bit bp, input bit early, input bit sbusy,
                           input bit rst_mid, input bit exp_perr);
    int d0, cyc, delay, stall, served;
    bit bp_done, early_done, sb_done, ack_seen, aborted;
    d0 = done_cnt; served = start_cnt; delay = -1; stall = 0;
    bp_done = 0; early_done = 0; sb_done = 0; ack_seen = 0; aborted = 0;
    for (int t = 0; t < 3; t++) begin
      for (int p = 0; p < 5; p++) exp_q.push_back(mk_pkt(5'(p), 2'b00, 8'(t)));
      exp_q.push_back(mk_pkt(5'd10, 2'b01, 8'(t)));
    end
    @(posedge clk); #1 start = 1;
    cyc = 0;
    while (done_cnt == d0 && cyc < 400 && !aborted) begin
      @(posedge clk); #1;
      cyc++;
      start = 0;
      if (rst_mid && add_done_ack && timestep == 8'd1) begin
        rst = 1;
        #1;
        check("rst_ack", add_done_ack, 0);
        check("rst_valid", pkt_valid, 0);
        check("rst_data", pkt_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ts", timestep, 0);
        check("rst_done", layer_done, 0);
        add_done_req = 0;
        pkt_ready = 1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        aborted = 1;
      end else begin
        if (stall > 0) begin
          stall--;
          if (stall == 0) pkt_ready = 1;
        end else if (bp && !bp_done && pkt_valid && pkt_data[14:10] == 5'd2) begin
          pkt_ready = 0; stall = 3; bp_done = 1;
        end
        if (early && !early_done && pkt_valid && pkt_data[14:10] == 5'd1 && timestep == 8'd0) begin
          add_done_req = 1; early_done = 1;
        end
        if (sbusy && !sb_done && timestep == 8'd1 && busy && !pkt_valid && !add_done_ack) begin
          start = 1; sb_done = 1;
        end
        if (ack_seen) begin
          add_done_req = 0; ack_seen = 0;
        end else if (add_done_req && add_done_ack) begin
          ack_seen = 1;
        end
        if (start_cnt > served) begin
          served++;
          if (!add_done_req) delay = 3;
        end else if (delay > 0) begin
          delay--;
          if (delay == 0) begin
            add_done_req = 1; delay = -1;
          end
        end
      end
    end
    if (!aborted) begin
      repeat (4) @(posedge clk);
      #1;
      check("layer_done_count", done_cnt - d0, 1);
      check("final_timestep", timestep, 2);
      check("busy_idle", busy, 0);
      check("pkts_left", exp_q.size(), 0);
      check("proto_err", proto_err, exp_perr);
    end
  endtask

  task automatic run_small();
    int cyc, served, b0, d0, a0;
    served = s_start_cnt; b0 = s_busy_cnt; d0 = s_done_cnt; a0 = s_ack_rise;
    exp_s_q.push_back(mk_pkt(5'd0, 2'b00, 8'd0));
    exp_s_q.push_back(mk_pkt(5'd10, 2'b01, 8'd0));
    @(posedge clk); #1 s_start = 1;
    cyc = 0;
    while (s_done_cnt == d0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      s_start = 0;
      if (s_start_cnt > served) begin
        served++; s_req = 1;
      end else if (s_req && s_ack) begin
        s_req = 0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    // CFG + KICK + WAIT_ADD + ACK + NEXT + DONE
    check("s_busy_cycles", s_busy_cnt - b0, 6);
    check("s_layer_done_count", s_done_cnt - d0, 1);
    check("s_handshakes", s_ack_rise - a0, 1);
    check("s_pkts_left", exp_s_q.size(), 0);
    check("s_timestep", s_ts, 0);
    check("s_busy_idle", s_busy, 0);
    check("s_proto_err", s_perr, 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1; start = 0; pkt_ready = 1; add_done_req = 0;
    s_start = 0; s_pkt_ready = 1; s_req = 0;
    repeat (3) @(posedge clk);
    #1;
    check("init_valid", pkt_valid, 0);
    check("init_data", pkt_data, 0);
    check("init_ack", add_done_ack, 0);
    check("init_busy", busy, 0);
    check("init_done", layer_done, 0);
    check("init_ts", timestep, 0);
    check("init_perr", proto_err, 0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1 check("idle_no_start", busy, 0);

    run_layer(0, 0, 0, 0, 0);   // plain full run
    run_layer(1, 0, 1, 0, 0);   // backpressure on dst 2, start while busy
    run_layer(0, 1, 0, 0, 1);   // early adder request
    run_layer(0, 0, 0, 1, 1);   // reset during ACK of timestep 1
    run_layer(0, 0, 0, 0, 0);   // clean run after reset
    run_small();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_sched_ctrl.md
Name: conv_sched_ctrl

Overview:
- Clocked control-center scheduler for the single-CONV-layer NoC.
- Per timestep: sends a config packet to every PE, then a start packet to the ifmap/filter memory, then waits for the partial-sum adder to report that all outputs for that timestep are complete.
- Repeats for TOT_TIME timesteps, then pulses layer_done.
- Sits between the host start trigger, the router injection port, and the adder's done/ack handshake.

Parameters:
- WIDTH, 5, node address width.
- DATA_WIDTH, 20, packet width.
- NUM_PE, 5, number of PEs configured per timestep (1..2^WIDTH).
- PE_BASE, 0, address of PE 0; PE i is at PE_BASE+i.
- MEM_ADDR, 10, memory node address.
- CC_ADDR, 15, this block's source address.
- TOT_TIME, 3, timesteps per layer (1..2^(DATA_WIDTH-2*WIDTH-2)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle layer start request.
- pkt_data  out  DATA_WIDTH  packet to router.
- pkt_valid  out  1  packet valid.
- pkt_ready  in  1  router accepts packet.
- add_done_req  in  1  adder: all outputs of current timestep summed (level, 4-phase).
- add_done_ack  out  1  acknowledge to adder (level, 4-phase).
- busy  out  1  high in any state except IDLE.
- layer_done  out  1  one-cycle pulse when the layer finishes.
- timestep  out  8  current timestep index.
- proto_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst=1): state=IDLE; pkt_valid=0, pkt_data=0, add_done_ack=0, busy=0, layer_done=0, timestep=0, proto_err=0, pe_cnt=0. Reset mid-operation aborts immediately; any packet in flight is dropped (valid falls asynchronously).
- Packet format, MSB first:
  - src[WIDTH]=CC_ADDR
  - dst[WIDTH]
  - type[2]: 00=CFG, 01=START, 10/11 reserved
  - payload[DATA_WIDTH-2*WIDTH-2] = timestep, zero-extended
- Valid/ready rules:
  - Transfer occurs on a clock edge with pkt_valid&&pkt_ready.
  - pkt_data and pkt_valid are registered and held stable while pkt_valid&&!pkt_ready.
  - pkt_valid never drops without a transfer, except on reset.
- States:
  - IDLE: start=1 -> CFG_PE, pe_cnt=0, timestep=0. The next cycle shows pkt_valid=1 with dst=PE_BASE, type=CFG.
  - CFG_PE: on transfer, if pe_cnt==NUM_PE-1 -> KICK_MEM (next pkt dst=MEM_ADDR, type=START). Otherwise pe_cnt++ and the next packet targets PE_BASE+pe_cnt. With pkt_ready held high, one packet per cycle, no bubbles.
  - KICK_MEM: on transfer -> WAIT_ADD; pkt_valid=0 the following cycle.
  - WAIT_ADD: add_done_req=1 sampled -> ACK; add_done_ack=1 from the next cycle.
  - ACK: hold add_done_ack=1 until add_done_req=0 is sampled, then add_done_ack=0 and -> NEXT.
  - NEXT (1 cycle): if timestep==TOT_TIME-1 -> DONE. Otherwise timestep++, pe_cnt=0 -> CFG_PE.
  - DONE (1 cycle): layer_done=1 -> IDLE. timestep keeps its final value until the next start.
- busy=1 in all states except IDLE, including DONE.
- start while busy is ignored: no restart, no error.
- add_done_req=1 sampled in CFG_PE or KICK_MEM sets proto_err=1 and the request is ignored. The adder holds req high, so it is serviced once WAIT_ADD is reached. proto_err clears only on reset.
- start and layer_done never coincide. start arriving in the DONE cycle is ignored; start is sampled only in IDLE.
- Latency with pkt_ready=1 and immediate 4-phase adder, per timestep: NUM_PE+1 packet cycles + WAIT_ADD + ACK cycles + NEXT.

Test Plan:
- Full run: NUM_PE=5, TOT_TIME=3, pkt_ready=1. Adder asserts req 4 cycles after the START packet and drops it 1 cycle after ack. Required: 18 packets in order (PE0..PE4 CFG, MEM START) with payload 0,0,0,0,0,0 then 1s then 2s; exactly one layer_done pulse; timestep=2 at end; busy falls the cycle after layer_done.
- Backpressure: pkt_ready low for 3 cycles on the 3rd CFG packet (dst=2). Required: pkt_data and pkt_valid stable for those 3 cycles; no duplicate or skipped dst; total sequence unchanged.
- Early adder req: add_done_req=1 while CFG_PE is sending PE1. Required: proto_err=1 and stays 1; ack not asserted until after the START packet transfers; run still completes.
- Start while busy: pulse start during WAIT_ADD of timestep 1. Required: no effect on state or packet sequence; one layer_done only.
- Reset mid-run: rst=1 during ACK of timestep 1. Required: all outputs reach reset values immediately (add_done_ack=0, pkt_valid=0). After release, a new start produces a clean sequence beginning with payload 0.
- TOT_TIME=1, NUM_PE=1: start. Required: exactly 2 packets (PE_BASE CFG, MEM START), one adder handshake, layer_done, total busy duration per the latency formula.
